// File: rtl/phase_monitor.sv
// Stepper coil phase monitor: tracks step direction, position and step counts, flags faults.
// Optional stall detection is built only when PHASE_MONITOR_STALL_EN is defined.
module phase_monitor #(
    parameter int unsigned STALL_LIMIT = 16
) (
    input  logic        CLK,
    input  logic        nReset,
    input  logic [3:0]  Phase,
    input  logic        Clear,
    output logic        Dir,
    output logic [11:0] Position,
    output logic [9:0]  FwdSteps,
    output logic [9:0]  RevSteps,
    output logic        DirChange,
    output logic        Stall,
    output logic        Fault
);

    typedef enum logic [1:0] {IDLE, TRACK, FAULT} state_t;

    state_t      state_q;
    logic [3:0]  phase_q;
    logic        dir_q;
    logic [11:0] pos_q;
    logic [9:0]  fwd_q;
    logic [9:0]  rev_q;
    logic        dchg_q;
    logic        fault_q;
    logic        stepped_q;   // a step has been counted since leaving IDLE

    logic        onehot_d;
    logic [3:0]  fwd_nxt_d;
    logic [3:0]  rev_nxt_d;
    logic        fwd_step_d;
    logic        rev_step_d;

    always_comb begin
        onehot_d   = (Phase != 4'd0) && ((Phase & (Phase - 4'd1)) == 4'd0);
        // Forward order 1->8->4->2->1 is a rotate right of the coil word
        fwd_nxt_d  = {phase_q[0], phase_q[3:1]};
        rev_nxt_d  = {phase_q[2:0], phase_q[3]};
        fwd_step_d = (state_q == TRACK) && !Clear && onehot_d && (Phase == fwd_nxt_d);
        rev_step_d = (state_q == TRACK) && !Clear && onehot_d && (Phase == rev_nxt_d);
    end

    always_ff @(posedge CLK or negedge nReset) begin
        if (!nReset) begin
            state_q   <= IDLE;
            phase_q   <= 4'd0;
            dir_q     <= 1'b0;
            pos_q     <= 12'd0;
            fwd_q     <= 10'd0;
            rev_q     <= 10'd0;
            dchg_q    <= 1'b0;
            fault_q   <= 1'b0;
            stepped_q <= 1'b0;
        end else if (Clear) begin
            state_q   <= IDLE;
            phase_q   <= 4'd0;
            dir_q     <= 1'b0;
            pos_q     <= 12'd0;
            fwd_q     <= 10'd0;
            rev_q     <= 10'd0;
            dchg_q    <= 1'b0;
            fault_q   <= 1'b0;
            stepped_q <= 1'b0;
        end else begin
            dchg_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (onehot_d) begin
                        phase_q <= Phase;
                        state_q <= TRACK;
                    end else begin
                        state_q <= FAULT;
                        fault_q <= 1'b1;
                    end
                end
                TRACK: begin
                    if (fwd_step_d) begin
                        phase_q   <= Phase;
                        pos_q     <= pos_q + 12'd1;
                        if (fwd_q != 10'h3FF) fwd_q <= fwd_q + 10'd1;
                        dchg_q    <= stepped_q && dir_q;
                        dir_q     <= 1'b0;
                        stepped_q <= 1'b1;
                    end else if (rev_step_d) begin
                        phase_q   <= Phase;
                        pos_q     <= pos_q - 12'd1;
                        if (rev_q != 10'h3FF) rev_q <= rev_q + 10'd1;
                        dchg_q    <= stepped_q && !dir_q;
                        dir_q     <= 1'b1;
                        stepped_q <= 1'b1;
                    end else if (Phase != phase_q) begin
                        // Non-one-hot word or a two-position jump
                        state_q <= FAULT;
                        fault_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= FAULT;
                    fault_q <= 1'b1;
                end
            endcase
        end
    end

`ifdef PHASE_MONITOR_STALL_EN
    localparam logic [7:0] LIM = 8'(STALL_LIMIT);

    logic [7:0] scnt_q;
    logic [7:0] scnt_d;
    logic       stall_q;
    logic       hold_d;

    always_comb begin
        hold_d = (state_q == TRACK) && (Phase == phase_q);
        scnt_d = scnt_q;
        if (Clear || fwd_step_d || rev_step_d) scnt_d = 8'd0;
        else if (hold_d && scnt_q < LIM)       scnt_d = scnt_q + 8'd1;
    end

    always_ff @(posedge CLK or negedge nReset) begin
        if (!nReset) begin
            scnt_q  <= 8'd0;
            stall_q <= 1'b0;
        end else begin
            scnt_q  <= scnt_d;
            stall_q <= (scnt_d >= LIM);
        end
    end

    assign Stall = stall_q;
`else
    assign Stall = 1'b0;
`endif

    assign Dir       = dir_q;
    assign Position  = pos_q;
    assign FwdSteps  = fwd_q;
    assign RevSteps  = rev_q;
    assign DirChange = dchg_q;
    assign Fault     = fault_q;

endmodule

// File: doc/phase_monitor.md
PHASE_MONITOR -- requirements
Module: phase_monitor

Interface
REQ-001 Parameter STALL_LIMIT, default 16, meaning: number of consecutive cycles with no step in TRACK before Stall asserts (legal range 1..255).
REQ-002 CLK  input  1  rising-edge clock for all state.
REQ-003 nReset  input  1  asynchronous active-low reset.
REQ-004 Phase  input  4  stepper coil drive word from the wash controller; legal values 4'd1, 4'd2, 4'd4, 4'd8.
REQ-005 Clear  input  1  synchronous clear of counters, flags and state.
REQ-006 Dir  output  1  direction of last valid step: 0 forward (1->8->4->2->1), 1 reverse (1->2->4->8->1).
REQ-007 Position  output  12  signed two's-complement step position.
REQ-008 FwdSteps  output  10  count of forward steps.
REQ-009 RevSteps  output  10  count of reverse steps.
REQ-010 DirChange  output  1  one-cycle pulse on a direction reversal.
REQ-011 Stall  output  1  no step seen for STALL_LIMIT cycles.
REQ-012 Fault  output  1  illegal Phase value or illegal transition detected; sticky.

Function
REQ-013 Phase is sampled on every CLK rising edge into PhaseQ; each edge compares the incoming Phase against PhaseQ; all outputs are registered and reflect a change one cycle after Phase changes.
REQ-014 State machine with states IDLE, TRACK, FAULT; only IDLE to TRACK, IDLE to FAULT, TRACK to FAULT, and any state to IDLE on Clear are legal.
REQ-015 IDLE: the first cycle with a legal one-hot Phase loads PhaseQ and moves to TRACK with no step counted; a non-one-hot Phase moves to FAULT.
REQ-016 TRACK: Phase == PhaseQ is a hold, with no count change and the stall counter incremented.
REQ-017 TRACK: Phase equal to the forward successor of PhaseQ is one forward step: Position +1, FwdSteps +1, Dir = 0.
REQ-018 TRACK: Phase equal to the reverse successor of PhaseQ is one reverse step: Position -1, RevSteps +1, Dir = 1.
REQ-019 TRACK: a non-one-hot Phase (including 0), or a two-position jump (1<->4, 2<->8), moves to FAULT and sets Fault = 1 on the next cycle.
REQ-020 DirChange pulses exactly one cycle when a step's direction differs from Dir set by the previous step; the first step after IDLE produces no pulse.
REQ-021 FwdSteps and RevSteps saturate at 1023; Position wraps modulo 4096 (2047 + 1 -> -2048).
REQ-022 The stall counter resets to 0 on every step; Stall = 1 when the counter reaches STALL_LIMIT, the counter then saturates, and Stall clears the cycle after the next step.
REQ-023 FAULT: all counters, Dir and Stall freeze; Fault stays 1 until Clear or reset; Phase is ignored.
REQ-024 Clear has priority over a simultaneous step or fault: counters zero, flags clear, state IDLE, the same-cycle step is not counted.
REQ-025 Wrap of PhaseQ 2->1 (forward) and 8->1 (reverse) is a normal step, not a fault.

Reset
REQ-026 nReset low immediately forces state IDLE, PhaseQ = 0, Position = 0, FwdSteps = 0, RevSteps = 0, Dir = 0, DirChange = 0, Stall = 0, Fault = 0, stall counter = 0.
REQ-027 Reset asserted mid-step discards any pending update; after deassertion the block behaves as after power-up.

Configuration
REQ-028 Macro PHASE_MONITOR_STALL_EN defined: the stall counter and Stall output behave per REQ-022.
REQ-029 Macro PHASE_MONITOR_STALL_EN undefined: no stall counter is built, Stall is tied to 0, and all other behaviour is unchanged.

Verification
REQ-030 Reset, then Phase 1,8,4,2,1 each held 1 cycle -> TRACK, FwdSteps = 4, Position = 4, Dir = 0, no DirChange.
REQ-031 After REQ-030, drive Phase 2,4 -> RevSteps = 2, Position = 2, Dir = 1, DirChange high exactly one cycle after the 2 is sampled.
REQ-032 In TRACK with Phase 1, drive 4 -> Fault = 1 next cycle; further legal steps leave counts frozen; Clear -> IDLE with all outputs 0.
REQ-033 STALL_LIMIT = 16 and PHASE_MONITOR_STALL_EN defined: hold Phase 16 cycles -> Stall = 1; one forward step -> Stall = 0 the following cycle.
REQ-034 Step forward 1025 times -> FwdSteps = 1023; run Position to 2047, one further forward step -> Position = -2048; nReset pulsed mid-sequence -> all outputs 0 immediately.
